// File: rtl/spi_adxl362_pkg.sv
// +--------------------------------------------------------------------------+
// | spi_adxl362_pkg : ADXL362 command/register constants, FSM state type      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package spi_adxl362_pkg;

  localparam logic [7:0] ADXL_CMD_WRITE = 8'h0A;
  localparam logic [7:0] ADXL_CMD_READ  = 8'h0B;
  localparam logic [7:0] REG_POWER_CTL  = 8'h2D;
  localparam logic [7:0] REG_XDATA_L    = 8'h0E;
  localparam logic [7:0] VAL_MEASURE    = 8'h02;

  localparam int RD_LEN  = 8;
  localparam int CFG_LEN = 3;

  typedef enum logic [2:0] {
    ST_STARTUP  = 3'd0,
    ST_CFG_SETUP = 3'd1,
    ST_CFG_XFER = 3'd2,
    ST_GAP      = 3'd3,
    ST_WAIT     = 3'd4,
    ST_RD_SETUP = 3'd5,
    ST_RD_XFER  = 3'd6,
    ST_PUBLISH  = 3'd7
  } state_t;

  typedef logic signed [11:0] axis_t;

  function automatic logic [7:0] cfg_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    cfg_byte = ADXL_CMD_WRITE;
      3'd1:    cfg_byte = REG_POWER_CTL;
      default: cfg_byte = VAL_MEASURE;
    endcase
  endfunction

  // Bytes past the register address are dummies clocking out the burst.
  function automatic logic [7:0] rd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    rd_byte = ADXL_CMD_READ;
      3'd1:    rd_byte = REG_XDATA_L;
      default: rd_byte = 8'h00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_adxl362_ctrl.sv
// +--------------------------------------------------------------------------+
// | spi_adxl362_ctrl : ADXL362 config write + periodic XYZ burst-read sequencer|
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module spi_adxl362_ctrl
  import spi_adxl362_pkg::*;
#(
  parameter int STARTUP_CLKS       = 500_000,
  parameter int SAMPLE_PERIOD_CLKS = 100_000,
  parameter int CS_GAP_CLKS        = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  output logic [7:0] o_TX_Byte,
  output logic       o_TX_DV,
  input  logic       i_TX_Ready,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_SPI_CS_n,
  output axis_t      o_X,
  output axis_t      o_Y,
  output axis_t      o_Z,
  output logic       o_Data_Valid,
  output logic       o_Cfg_Done
);

  localparam int c_max_a     = (STARTUP_CLKS > SAMPLE_PERIOD_CLKS) ? STARTUP_CLKS : SAMPLE_PERIOD_CLKS;
  localparam int c_max_clks  = (c_max_a > CS_GAP_CLKS) ? c_max_a : CS_GAP_CLKS;
  localparam int c_tmr_w     = (c_max_clks > 1) ? $clog2(c_max_clks) : 1;
  localparam int c_rd_period = (SAMPLE_PERIOD_CLKS > CS_GAP_CLKS) ? SAMPLE_PERIOD_CLKS : CS_GAP_CLKS;

  localparam logic [c_tmr_w-1:0] c_startup_end = c_tmr_w'(STARTUP_CLKS - 1);
  localparam logic [c_tmr_w-1:0] c_gap_end     = c_tmr_w'(CS_GAP_CLKS - 1);
  localparam logic [c_tmr_w-1:0] c_period_end  = c_tmr_w'(c_rd_period - 1);
  localparam logic [2:0]         c_cfg_last    = 3'(CFG_LEN - 1);
  localparam logic [2:0]         c_rd_last     = 3'(RD_LEN - 1);

  state_t               r_state;
  logic [c_tmr_w-1:0]   r_timer;
  logic [2:0]           r_idx;
  logic                 r_outstanding;
  logic                 r_first_rd;
  logic [7:0]           r_xl, r_yl, r_zl;
  logic [3:0]           r_xh, r_yh;

  logic                 w_is_cfg;
  logic                 w_last;
  logic [7:0]           w_tx_byte;

  assign w_is_cfg  = (r_state == ST_CFG_XFER);
  assign w_last    = w_is_cfg ? (r_idx == c_cfg_last) : (r_idx == c_rd_last);
  assign w_tx_byte = w_is_cfg ? cfg_byte(r_idx) : rd_byte(r_idx);

  // r_timer runs continuously from the CS_n rising edge through PUBLISH/GAP/WAIT
  // so the read-to-read spacing is measured edge to edge.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state       <= ST_STARTUP;
      r_timer       <= '0;
      r_idx         <= '0;
      r_outstanding <= 1'b0;
      r_first_rd    <= 1'b0;
      r_xl          <= '0;
      r_xh          <= '0;
      r_yl          <= '0;
      r_yh          <= '0;
      r_zl          <= '0;
      o_TX_Byte     <= 8'h00;
      o_TX_DV       <= 1'b0;
      o_SPI_CS_n    <= 1'b1;
      o_X           <= '0;
      o_Y           <= '0;
      o_Z           <= '0;
      o_Data_Valid  <= 1'b0;
      o_Cfg_Done    <= 1'b0;
    end else begin
      o_TX_DV      <= 1'b0;
      o_Data_Valid <= 1'b0;
      case (r_state)
        ST_STARTUP: begin
          if (r_timer == c_startup_end) begin
            r_timer    <= '0;
            o_SPI_CS_n <= 1'b0;
            r_state    <= ST_CFG_SETUP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_CFG_SETUP, ST_RD_SETUP: begin
          if (r_timer == c_gap_end) begin
            r_timer       <= '0;
            r_idx         <= '0;
            r_outstanding <= 1'b0;
            r_state       <= (r_state == ST_CFG_SETUP) ? ST_CFG_XFER : ST_RD_XFER;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_CFG_XFER, ST_RD_XFER: begin
          if (!r_outstanding) begin
            if (i_TX_Ready) begin
              o_TX_DV       <= 1'b1;
              o_TX_Byte     <= w_tx_byte;
              r_outstanding <= 1'b1;
            end
          end else if (i_RX_DV) begin
            r_outstanding <= 1'b0;
            r_idx         <= w_last ? 3'd0 : r_idx + 1'b1;
            if (!w_is_cfg) begin
              case (r_idx)
                3'd2: r_xl <= i_RX_Byte;
                3'd3: r_xh <= i_RX_Byte[3:0];
                3'd4: r_yl <= i_RX_Byte;
                3'd5: r_yh <= i_RX_Byte[3:0];
                3'd6: r_zl <= i_RX_Byte;
                3'd7: begin
                  // ZH arrives on this strobe, so Z is built straight from the bus.
                  o_X          <= {r_xh, r_xl};
                  o_Y          <= {r_yh, r_yl};
                  o_Z          <= {i_RX_Byte[3:0], r_zl};
                  o_Data_Valid <= 1'b1;
                end
                default: ;
              endcase
            end
            if (w_last) begin
              o_SPI_CS_n <= 1'b1;
              r_timer    <= '0;
              if (w_is_cfg) begin
                o_Cfg_Done <= 1'b1;
                r_first_rd <= 1'b1;
                r_state    <= ST_GAP;
              end else begin
                r_state    <= ST_PUBLISH;
              end
            end
          end
        end
        ST_PUBLISH: begin
          r_timer <= r_timer + 1'b1;
          r_state <= ST_GAP;
        end
        ST_GAP: begin
          if (r_timer >= c_gap_end) begin
            if (r_first_rd || (r_timer >= c_period_end)) begin
              r_timer    <= '0;
              r_first_rd <= 1'b0;
              o_SPI_CS_n <= 1'b0;
              r_state    <= ST_RD_SETUP;
            end else begin
              r_timer <= r_timer + 1'b1;
              r_state <= ST_WAIT;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_WAIT: begin
          if (r_timer >= c_period_end) begin
            r_timer    <= '0;
            o_SPI_CS_n <= 1'b0;
            r_state    <= ST_RD_SETUP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= ST_STARTUP;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_adxl362_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_spi_adxl362_ctrl : directed bench with SPI core + ADXL362 slave model  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_spi_adxl362_ctrl;

  localparam int c_startup = 20;
  localparam int c_gap     = 2;
  localparam int c_period  = 200;
  localparam int c_lat     = 3;

  logic              i_Clk = 1'b0;
  logic              i_Rst = 1'b1;
  logic [7:0]        o_TX_Byte;
  logic              o_TX_DV;
  logic              i_TX_Ready = 1'b1;
  logic              i_RX_DV = 1'b0;
  logic [7:0]        i_RX_Byte = 8'h00;
  logic              o_SPI_CS_n;
  logic signed [11:0] o_X, o_Y, o_Z;
  logic              o_Data_Valid;
  logic              o_Cfg_Done;

  always #5 i_Clk = ~i_Clk;

  spi_adxl362_ctrl #(
    .STARTUP_CLKS       (c_startup),
    .SAMPLE_PERIOD_CLKS (c_period),
    .CS_GAP_CLKS        (c_gap)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .o_TX_Byte    (o_TX_Byte),
    .o_TX_DV      (o_TX_DV),
    .i_TX_Ready   (i_TX_Ready),
    .i_RX_DV      (i_RX_DV),
    .i_RX_Byte    (i_RX_Byte),
    .o_SPI_CS_n   (o_SPI_CS_n),
    .o_X          (o_X),
    .o_Y          (o_Y),
    .o_Z          (o_Z),
    .o_Data_Valid (o_Data_Valid),
    .o_Cfg_Done   (o_Cfg_Done)
  );

  int total = 0;
  int bad   = 0;

  int cyc = 0, tx_count = 0, rx_total = 0, dv_count = 0, viol = 0, dv_double = 0;
  int n_fall = 0, n_rise = 0, rx_cyc_last = 0, dv_rx_gap = -1, cfg_rx_gap = -1;
  int fall_cyc [16];
  int rise_cyc [16];
  logic [7:0] tx_log [64];
  logic [7:0] tbl [6];
  logic stall = 1'b0, busy = 1'b0, cs_prev = 1'b1, dv_prev = 1'b0, cfg_prev = 1'b0;
  int cnt = 0, pos = 0, cur_pos = 0;

  // Byte-level SPI core with fixed latency plus ADXL362 slave returning tbl[].
  initial begin : core_model
    forever begin
      @(negedge i_Clk);
      cyc++;
      if (o_SPI_CS_n !== cs_prev) begin
        if (o_SPI_CS_n === 1'b0) begin
          if (n_fall < 16) fall_cyc[n_fall] = cyc;
          n_fall++;
        end else begin
          if (n_rise < 16) rise_cyc[n_rise] = cyc;
          n_rise++;
        end
      end
      cs_prev = o_SPI_CS_n;
      if (o_SPI_CS_n) pos = 0;
      if (o_Data_Valid) begin
        dv_count++;
        dv_rx_gap = cyc - rx_cyc_last;
        if (dv_prev) dv_double++;
      end
      dv_prev = o_Data_Valid;
      if (o_Cfg_Done && !cfg_prev) cfg_rx_gap = cyc - rx_cyc_last;
      cfg_prev = o_Cfg_Done;

      i_RX_DV = 1'b0;
      if (o_TX_DV) begin
        if (busy || o_SPI_CS_n) viol++;
        if (tx_count < 64) tx_log[tx_count] = o_TX_Byte;
        tx_count++;
        busy    = 1'b1;
        cnt     = c_lat;
        cur_pos = pos;
        pos++;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          busy      = 1'b0;
          i_RX_DV   = 1'b1;
          i_RX_Byte = (cur_pos >= 2 && cur_pos <= 7) ? tbl[cur_pos-2] : 8'hA5;
          rx_total++;
          rx_cyc_last = cyc;
        end
      end
      i_TX_Ready = !busy && !stall;
    end
  end

  task automatic test_reset;
    int n_hi;
    tbl[0] = 8'h34; tbl[1] = 8'h02; tbl[2] = 8'hFF;
    tbl[3] = 8'hFF; tbl[4] = 8'h00; tbl[5] = 8'h08;
    i_Rst = 1'b1;
    repeat (3) @(negedge i_Clk);
    total++; if (o_SPI_CS_n !== 1'b1) begin bad++; $display("FAIL reset_cs: got %b want 1", o_SPI_CS_n); end
    total++; if ({o_TX_DV, o_TX_Byte} !== 9'h000) begin bad++; $display("FAIL reset_tx: got %h want 000", {o_TX_DV, o_TX_Byte}); end
    total++; if ({o_X, o_Y, o_Z} !== 36'h0) begin bad++; $display("FAIL reset_xyz: got %h want 0", {o_X, o_Y, o_Z}); end
    total++; if ({o_Data_Valid, o_Cfg_Done} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {o_Data_Valid, o_Cfg_Done}); end
    i_Rst = 1'b0;
    n_hi  = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_Clk);
      if (k < 20 && o_SPI_CS_n === 1'b1) n_hi++;
      if (k == 20) begin
        total++; if (o_SPI_CS_n !== 1'b0) begin bad++; $display("FAIL startup_cs_fall: got %b want 0", o_SPI_CS_n); end
      end
    end
    total++; if (n_hi != 19) begin bad++; $display("FAIL startup_cs_high: got %0d want 19", n_hi); end
  endtask

  task automatic test_config;
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge i_Clk);
      if (o_Cfg_Done) begin ok = 1; break; end
    end
    @(negedge i_Clk);
    total++; if (!ok) begin bad++; $display("FAIL cfg_timeout: got 0 want 1"); end
    total++; if (tx_count != 3) begin bad++; $display("FAIL cfg_tx_count: got %0d want 3", tx_count); end
    total++; if ({tx_log[0], tx_log[1], tx_log[2]} !== 24'h0A2D02) begin bad++; $display("FAIL cfg_bytes: got %h want 0a2d02", {tx_log[0], tx_log[1], tx_log[2]}); end
    total++; if (n_fall != 1 || n_rise != 1) begin bad++; $display("FAIL cfg_cs_edges: got %0d/%0d want 1/1", n_fall, n_rise); end
    total++; if (cfg_rx_gap != 1) begin bad++; $display("FAIL cfg_done_latency: got %0d want 1", cfg_rx_gap); end
  endtask

  task automatic test_read;
    bit ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge i_Clk);
      if (dv_count >= 1) begin ok = 1; break; end
    end
    @(negedge i_Clk);
    total++; if (!ok) begin bad++; $display("FAIL read_timeout: got 0 want 1"); end
    total++; if (o_X !== 12'h234) begin bad++; $display("FAIL read_x: got %h want 234", o_X); end
    total++; if (o_Y !== 12'hFFF) begin bad++; $display("FAIL read_y: got %h want fff", o_Y); end
    total++; if (o_Z !== 12'h800) begin bad++; $display("FAIL read_z: got %h want 800", o_Z); end
    total++; if (dv_rx_gap != 1) begin bad++; $display("FAIL read_dv_latency: got %0d want 1", dv_rx_gap); end
    total++; if (o_Data_Valid !== 1'b0 || o_SPI_CS_n !== 1'b1) begin bad++; $display("FAIL read_after: got %b%b want 01", o_Data_Valid, o_SPI_CS_n); end
    total++;
    if ({tx_log[3], tx_log[4], tx_log[5], tx_log[6], tx_log[7], tx_log[8], tx_log[9], tx_log[10]} !== 64'h0B0E_0000_0000_0000) begin
      bad++; $display("FAIL read_bytes: got %h want 0b0e000000000000",
                      {tx_log[3], tx_log[4], tx_log[5], tx_log[6], tx_log[7], tx_log[8], tx_log[9], tx_log[10]});
    end
    tbl[0] = 8'hFF; tbl[1] = 8'hF7; tbl[2] = 8'h01;
    tbl[3] = 8'hF8; tbl[4] = 8'hAA; tbl[5] = 8'h05;
  endtask

  task automatic test_period;
    bit ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge i_Clk);
      if (dv_count >= 2) begin ok = 1; break; end
    end
    @(negedge i_Clk);
    total++; if (!ok) begin bad++; $display("FAIL period_timeout: got 0 want 1"); end
    total++; if (fall_cyc[1] - rise_cyc[0] != c_gap) begin bad++; $display("FAIL first_gap: got %0d want %0d", fall_cyc[1] - rise_cyc[0], c_gap); end
    total++; if (fall_cyc[2] - rise_cyc[1] != c_period) begin bad++; $display("FAIL period: got %0d want %0d", fall_cyc[2] - rise_cyc[1], c_period); end
    total++; if ({o_X, o_Y, o_Z} !== 36'h7FF_801_5AA) begin bad++; $display("FAIL read2_xyz: got %h want 7ff8015aa", {o_X, o_Y, o_Z}); end
  endtask

  task automatic test_stall;
    bit ok = 0;
    int cs_hi = 0;
    int tx_hold;
    for (int i = 0; i < 1000; i++) begin
      @(negedge i_Clk);
      if (tx_count >= 20) begin ok = 1; break; end
    end
    stall = 1'b1;
    total++; if (!ok) begin bad++; $display("FAIL stall_timeout: got 0 want 1"); end
    for (int i = 0; i < 50; i++) begin
      @(negedge i_Clk);
      if (o_SPI_CS_n !== 1'b0) cs_hi++;
    end
    tx_hold = tx_count;
    stall   = 1'b0;
    total++; if (tx_hold != 20) begin bad++; $display("FAIL stall_no_tx: got %0d want 20", tx_hold); end
    total++; if (cs_hi != 0) begin bad++; $display("FAIL stall_cs_low: got %0d want 0", cs_hi); end
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge i_Clk);
      if (dv_count >= 3) begin ok = 1; break; end
    end
    @(negedge i_Clk);
    total++; if (!ok) begin bad++; $display("FAIL stall_resume_timeout: got 0 want 1"); end
    total++; if (tx_log[20] !== 8'h0E || tx_count != 27) begin bad++; $display("FAIL stall_next_byte: got %h/%0d want 0e/27", tx_log[20], tx_count); end
    total++; if ({o_X, o_Y, o_Z} !== 36'h7FF_801_5AA) begin bad++; $display("FAIL stall_xyz: got %h want 7ff8015aa", {o_X, o_Y, o_Z}); end
  endtask

  task automatic test_reset_mid;
    bit ok = 0;
    int dv_before, tx_at_rst, n;
    for (int i = 0; i < 1000; i++) begin
      @(negedge i_Clk);
      if (rx_total >= 31) begin ok = 1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL mid_timeout: got 0 want 1"); end
    dv_before = dv_count;
    i_Rst = 1'b1;
    @(negedge i_Clk);
    i_Rst = 1'b0;
    total++; if ({o_SPI_CS_n, o_TX_DV, o_Data_Valid, o_Cfg_Done} !== 4'b1000) begin bad++; $display("FAIL mid_rst_flags: got %b want 1000", {o_SPI_CS_n, o_TX_DV, o_Data_Valid, o_Cfg_Done}); end
    total++; if ({o_X, o_Y, o_Z} !== 36'h0) begin bad++; $display("FAIL mid_rst_xyz: got %h want 0", {o_X, o_Y, o_Z}); end
    tx_at_rst = tx_count;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_Clk);
      n++;
      if (o_SPI_CS_n === 1'b0) break;
    end
    total++; if (n != c_startup) begin bad++; $display("FAIL mid_restart_delay: got %0d want %0d", n, c_startup); end
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge i_Clk);
      if (o_Cfg_Done) begin ok = 1; break; end
    end
    @(negedge i_Clk);
    total++; if (!ok) begin bad++; $display("FAIL mid_cfg_timeout: got 0 want 1"); end
    total++; if (dv_count != dv_before) begin bad++; $display("FAIL mid_no_dv: got %0d want %0d", dv_count, dv_before); end
    total++;
    if (tx_at_rst > 61 || {tx_log[tx_at_rst], tx_log[tx_at_rst+1], tx_log[tx_at_rst+2]} !== 24'h0A2D02 || tx_count != tx_at_rst + 3) begin
      bad++; $display("FAIL mid_cfg_redo: got count %0d want %0d", tx_count, tx_at_rst + 3);
    end
  endtask

  initial begin
    test_reset;
    test_config;
    test_read;
    test_period;
    test_stall;
    test_reset_mid;
    total++; if (viol != 0) begin bad++; $display("FAIL tx_protocol: got %0d want 0", viol); end
    total++; if (dv_double != 0) begin bad++; $display("FAIL dv_pulse_width: got %0d want 0", dv_double); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
